// File: rtl/boot_loader_pkg.sv
// Shared constants, FSM state encoding and helpers for the boot loader.
package boot_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned LEN_W          = 16;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IDX_W          = 2;
    localparam int unsigned SHIFT_W        = WORD_W - BYTE_W;

    localparam logic [BYTE_W-1:0] BOOT_CMD_INSTR = 8'h00;
    localparam logic [BYTE_W-1:0] BOOT_CMD_DATA  = 8'h01;
    localparam logic [BYTE_W-1:0] BOOT_CMD_GO    = 8'hFF;

    typedef enum logic [2:0] {
        CMD,
        LEN0,
        LEN1,
        DATA,
        EMIT,
        CSUM,
        DONE,
        ERR
    } boot_state_t;

    // True for command bytes that open a write frame.
    function automatic logic is_frame_cmd(input logic [BYTE_W-1:0] b);
        return (b == BOOT_CMD_INSTR) || (b == BOOT_CMD_DATA);
    endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Little-endian byte-to-word assembler; the word is complete combinationally on the 4th push.
module boot_word_packer
    import boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              areset_n,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_c,
    output logic              word_full_c
);

    // Only the three earlier bytes are stored; the 4th is taken straight from the input.
    logic [SHIFT_W-1:0] sr_q, sr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (clear_i) begin
            sr_d  = '0;
            idx_d = '0;
        end else if (push_i) begin
            sr_d  = {byte_i, sr_q[SHIFT_W-1:BYTE_W]};
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

    assign word_c      = {byte_i, sr_q};
    assign word_full_c = push_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/boot_loader.sv
// Byte-stream boot loader: assembles LE words into instr/data preload writes, releases core on GO.
// Optional BOOT_LOADER_CHECKSUM_EN: each non-empty frame ends with an XOR checksum byte.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              preload_en_instr,
    output logic              preload_en_data,
    output logic [ADDR_W-1:0] preload_addr,
    output logic [DATA_W-1:0] preload_data,
    output logic              core_rst_n,
    output logic              done,
    output logic              error
);

    boot_state_t       state_q, state_d;
    logic              s_ready_q, s_ready_d;
    logic              en_instr_q, en_instr_d;
    logic              en_data_q, en_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              target_q, target_d;
    logic [BYTE_W-1:0] len_lo_q, len_lo_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    logic              accept_c;
    logic              pack_clear_c;
    logic              pack_push_c;
    logic [WORD_W-1:0] word_c;
    logic              word_full_c;
    logic [LEN_W-1:0]  len_c;

    assign accept_c = s_valid && s_ready_q;
    assign len_c    = {s_data, len_lo_q};

    boot_word_packer u_packer (
        .clk         (clk),
        .areset_n    (areset_n),
        .clear_i     (pack_clear_c),
        .push_i      (pack_push_c),
        .byte_i      (s_data),
        .word_c      (word_c),
        .word_full_c (word_full_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        s_ready_d    = s_ready_q;
        en_instr_d   = 1'b0;
        en_data_d    = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        target_d     = target_q;
        len_lo_d     = len_lo_q;
        remain_d     = remain_q;
        core_rst_n_d = core_rst_n_q;
        done_d       = done_q;
        error_d      = error_q;
        pack_clear_c = 1'b0;
        pack_push_c  = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif

        case (state_q)
            CMD: begin
                s_ready_d = 1'b1;
                if (accept_c) begin
                    if (is_frame_cmd(s_data)) begin
                        target_d     = (s_data == BOOT_CMD_DATA);
                        addr_d       = '0;
                        pack_clear_c = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                        csum_d       = '0;
`endif
                        state_d      = LEN0;
                    end else if (s_data == BOOT_CMD_GO) begin
                        s_ready_d    = 1'b0;
                        done_d       = 1'b1;
                        core_rst_n_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        s_ready_d = 1'b0;
                        error_d   = 1'b1;
                        state_d   = ERR;
                    end
                end
            end
            LEN0: begin
                if (accept_c) begin
                    len_lo_d = s_data;
                    state_d  = LEN1;
                end
            end
            LEN1: begin
                if (accept_c) begin
                    remain_d = len_c;
                    state_d  = (len_c == '0) ? CMD : DATA;
                end
            end
            DATA: begin
                if (accept_c) begin
                    pack_push_c = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ s_data;
`endif
                    if (word_full_c) begin
                        s_ready_d  = 1'b0;
                        data_d     = DATA_W'(word_c);
                        en_instr_d = !target_q;
                        en_data_d  = target_q;
                        state_d    = EMIT;
                    end
                end
            end
            EMIT: begin
                addr_d    = addr_q + ADDR_W'(BYTES_PER_WORD);
                remain_d  = remain_q - LEN_W'(1);
                s_ready_d = 1'b1;
                if (remain_q == LEN_W'(1)) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = CMD;
`endif
                end else begin
                    state_d = DATA;
                end
            end
            CSUM: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                if (accept_c) begin
                    if (s_data == csum_q) begin
                        state_d = CMD;
                    end else begin
                        s_ready_d = 1'b0;
                        error_d   = 1'b1;
                        state_d   = ERR;
                    end
                end
`else
                s_ready_d = 1'b0;
                error_d   = 1'b1;
                state_d   = ERR;
`endif
            end
            DONE, ERR: begin
                s_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= CMD;
            s_ready_q    <= 1'b0;
            en_instr_q   <= 1'b0;
            en_data_q    <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            target_q     <= 1'b0;
            len_lo_q     <= '0;
            remain_q     <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            s_ready_q    <= s_ready_d;
            en_instr_q   <= en_instr_d;
            en_data_q    <= en_data_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            target_q     <= target_d;
            len_lo_q     <= len_lo_d;
            remain_q     <= remain_d;
            core_rst_n_q <= core_rst_n_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign s_ready          = s_ready_q;
    assign preload_en_instr = en_instr_q;
    assign preload_en_data  = en_data_q;
    assign preload_addr     = addr_q;
    assign preload_data     = data_q;
    assign core_rst_n       = core_rst_n_q;
    assign done             = done_q;
    assign error            = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader with a write scoreboard; exercises BOOT_LOADER_CHECKSUM_EN when defined.
module tb_boot_loader;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              areset_n = 1'b0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'h00;
    logic              s_ready;
    logic              preload_en_instr;
    logic              preload_en_data;
    logic [ADDR_W-1:0] preload_addr;
    logic [DATA_W-1:0] preload_data;
    logic              core_rst_n;
    logic              done;
    logic              error;

    typedef struct packed {
        logic              tgt;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_strobes = 0;
    int          s0;

    boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .areset_n         (areset_n),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .preload_en_instr (preload_en_instr),
        .preload_en_data  (preload_en_data),
        .preload_addr     (preload_addr),
        .preload_data     (preload_data),
        .core_rst_n       (core_rst_n),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every strobe must match the oldest pending expected write.
    always @(negedge clk) begin
        if (areset_n && (preload_en_instr || preload_en_data)) begin
            n_strobes++;
            if (exp_q.size() == 0) begin
                check("strobe_without_expectation", 64'({preload_en_data, preload_en_instr}), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_target", 64'({preload_en_data, preload_en_instr}),
                      e.tgt ? 64'(2'b10) : 64'(2'b01));
                check("strobe_addr", 64'(preload_addr), 64'(e.addr));
                check("strobe_data", 64'(preload_data), 64'(e.data));
            end
        end
    end

    // Drive one byte at a negedge and hold it until the handshake edge has passed.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (s_ready !== 1'b1) begin
            check("handshake_timeout", 64'(s_ready), 64'(1));
        end else begin
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] words[$], input int max_gap);
        int          n;
        logic [7:0]  by;
`ifdef BOOT_LOADER_CHECKSUM_EN
        logic [7:0]  cs;
        cs = 8'h00;
`endif
        n = words.size();
        send_byte(cmd, 0);
        send_byte(8'(n), 0);
        send_byte(8'(n >> 8), 0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{tgt: (cmd == 8'h01), addr: ADDR_W'(4 * i), data: words[i]});
            for (int b = 0; b < 4; b++) begin
                by = words[i][8*b +: 8];
`ifdef BOOT_LOADER_CHECKSUM_EN
                cs = cs ^ by;
`endif
                send_byte(by, int'($urandom_range(max_gap, 0)));
            end
            check("strobe_latency", 64'({preload_en_data, preload_en_instr}),
                  (cmd == 8'h01) ? 64'(2'b10) : 64'(2'b01));
            check("ready_low_in_emit", 64'(s_ready), 64'(0));
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (n > 0) send_byte(cs, 0);
`endif
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        s_valid  = 1'b0;
        areset_n = 1'b0;
        repeat (2) @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_en", 64'({preload_en_instr, preload_en_data}), 64'(0));
        check("rst_addr", 64'(preload_addr), 64'(0));
        check("rst_data", 64'(preload_data), 64'(0));
        check("rst_core_rst_n", 64'(core_rst_n), 64'(0));
        check("rst_done_error", 64'({done, error}), 64'(0));
        areset_n = 1'b1;
        check("ready_before_first_edge", 64'(s_ready), 64'(0));
        @(negedge clk);
        check("ready_after_reset", 64'(s_ready), 64'(1));

        // Instruction frame: 00 02 00 13 00 00 00 93 00 10 00
        wq = {};
        wq.push_back(32'h0000_0013);
        wq.push_back(32'h0010_0093);
        send_frame(8'h00, wq, 0);
        drain("instr_frame_pending");

        // Data frame with random s_valid gaps
        wq = {};
        wq.push_back(32'h4433_2211);
        wq.push_back(32'h8877_6655);
        wq.push_back(32'hCAFE_F00D);
        send_frame(8'h01, wq, 3);
        drain("gapped_frame_pending");

        // Zero-length frame: no writes
        s0 = n_strobes;
        wq = {};
        send_frame(8'h00, wq, 0);
        drain("zero_frame_pending");
        check("zero_frame_no_strobe", 64'(n_strobes - s0), 64'(0));
        check("zero_frame_ready", 64'(s_ready), 64'(1));

        // Address wrap: 17 words into a 64-byte space
        wq = {};
        for (int i = 0; i < 17; i++) wq.push_back(32'h1000_0000 + 32'(i));
        send_frame(8'h00, wq, 1);
        drain("wrap_frame_pending");

        // Data word then GO
        wq = {};
        wq.push_back(32'hDEAD_BEEF);
        send_frame(8'h01, wq, 0);
        drain("deadbeef_pending");
        check("core_held_before_go", 64'(core_rst_n), 64'(0));
        send_byte(8'hFF, 0);
        check("go_done", 64'(done), 64'(1));
        check("go_core_rst_n", 64'(core_rst_n), 64'(1));
        check("go_ready", 64'(s_ready), 64'(0));
        check("go_error", 64'(error), 64'(0));
        s0 = n_strobes;
        s_valid = 1'b1;
        s_data  = 8'h00;
        repeat (5) @(negedge clk);
        s_valid = 1'b0;
        check("done_sticky", 64'({done, core_rst_n, s_ready}), 64'(3'b110));
        check("done_no_strobe", 64'(n_strobes - s0), 64'(0));

        // Reset while done, then abandon a frame mid-word
        do_reset();
        check("rerst_done_cleared", 64'({done, core_rst_n}), 64'(0));
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        areset_n = 1'b0;
        #1;
        check("midframe_rst_ready", 64'(s_ready), 64'(0));
        check("midframe_rst_addr", 64'(preload_addr), 64'(0));
        repeat (2) @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);
        wq = {};
        wq.push_back(32'h0BAD_C0DE);
        send_frame(8'h00, wq, 0);
        drain("after_midframe_rst_pending");

        // Illegal command byte
        send_byte(8'h42, 0);
        check("bad_cmd_error", 64'(error), 64'(1));
        check("bad_cmd_ready", 64'(s_ready), 64'(0));
        check("bad_cmd_core_rst_n", 64'(core_rst_n), 64'(0));
        s0 = n_strobes;
        s_valid = 1'b1;
        s_data  = 8'hFF;
        repeat (5) @(negedge clk);
        s_valid = 1'b0;
        check("err_sticky", 64'({error, done, core_rst_n}), 64'(3'b100));
        check("err_no_strobe", 64'(n_strobes - s0), 64'(0));

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Bad checksum: 01 01 00 01 02 03 04 05 (expected 04)
        do_reset();
        exp_q.push_back('{tgt: 1'b1, addr: ADDR_W'(0), data: 32'h0403_0201});
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        check("csum_frame_strobe", 64'(preload_en_data), 64'(1));
        send_byte(8'h05, 0);
        check("csum_bad_error", 64'(error), 64'(1));
        check("csum_bad_ready", 64'(s_ready), 64'(0));
        drain("csum_frame_pending");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
